adder_share_sched: RTL and testbench

Round-robin scheduler that shares one 8-bit ripple byte adder slice among NREQ requesters. Each request carries two multi-byte operands. The block runs the add one byte per cycle, least-significant byte first, chaining the carry between bytes. It returns the (8*NBYTES+1)-bit sum tagged with the requester index. It sits between several approximate/exact datapath clients and a single shared adder resource.

---
 rtl/adder_share_sched.sv | 177 +++++++++++++++++
 tb/tb_adder_share_sched.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_share_sched.sv
// Round-robin arbiter sharing a single 8-bit adder slice among NREQ requesters.
// Operands are added one byte per cycle, LSB first, with a registered carry.
module adder_share_sched #(
    parameter int NREQ   = 4,
    parameter int NBYTES = 2,
    parameter int IDW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*8*NBYTES-1:0] req_a,
    input  logic [NREQ*8*NBYTES-1:0] req_b,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [IDW-1:0]         rsp_id,
    output logic [8*NBYTES:0]      rsp_sum,
    output logic                   busy
);

    localparam int W  = 8 * NBYTES;
    localparam int KW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        RESP
    } state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [KW-1:0]  k_q, k_d;
    logic           carry_q, carry_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0] rsp_id_q, rsp_id_d;
    logic [W:0]     rsp_sum_q, rsp_sum_d;
    logic           busy_q, busy_d;
    logic [IDW-1:0] gnt_id_q, gnt_id_d;
    logic [W-1:0]   op_a_q, op_a_d;
    logic [W-1:0]   op_b_q, op_b_d;

    logic           grant_found;
    logic [IDW-1:0] grant_idx;
    logic [7:0]     a_byte;
    logic [7:0]     b_byte;
    logic [8:0]     slice;

    // Rotating priority search starting at rr_ptr.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (!grant_found && req_valid[(int'(rr_ptr_q) + j) % NREQ]) begin
                grant_found = 1'b1;
                grant_idx   = IDW'((int'(rr_ptr_q) + j) % NREQ);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state_q == IDLE && grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // The one shared byte slice.
    always_comb begin
        a_byte = '0;
        b_byte = '0;
        for (int i = 0; i < NBYTES; i++) begin
            if (k_q == KW'(i)) begin
                a_byte = op_a_q[i*8 +: 8];
                b_byte = op_b_q[i*8 +: 8];
            end
        end
        slice = {1'b0, a_byte} + {1'b0, b_byte} + {8'b0, carry_q};
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        k_d         = k_q;
        carry_d     = carry_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_sum_d   = rsp_sum_q;
        busy_d      = busy_q;
        gnt_id_d    = gnt_id_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        unique case (state_q)
            IDLE: begin
                if (grant_found) begin
                    for (int i = 0; i < NREQ; i++) begin
                        if (grant_idx == IDW'(i)) begin
                            op_a_d = req_a[i*W +: W];
                            op_b_d = req_b[i*W +: W];
                        end
                    end
                    gnt_id_d = grant_idx;
                    if (grant_idx == IDW'(NREQ - 1)) begin
                        rr_ptr_d = '0;
                    end else begin
                        rr_ptr_d = grant_idx + IDW'(1);
                    end
                    k_d     = '0;
                    carry_d = 1'b0;
                    busy_d  = 1'b1;
                    state_d = ADD;
                end
            end
            ADD: begin
                for (int i = 0; i < NBYTES; i++) begin
                    if (k_q == KW'(i)) begin
                        rsp_sum_d[i*8 +: 8] = slice[7:0];
                    end
                end
                carry_d = slice[8];
                k_d     = k_q + KW'(1);
                if (k_q == KW'(NBYTES - 1)) begin
                    rsp_sum_d[W] = slice[8];
                    rsp_id_d     = gnt_id_q;
                    rsp_valid_d  = 1'b1;
                    k_d          = '0;
                    state_d      = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            k_q         <= '0;
            carry_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= '0;
            busy_q      <= 1'b0;
            gnt_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            k_q         <= k_d;
            carry_q     <= carry_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_sum_q   <= rsp_sum_d;
            busy_q      <= busy_d;
            gnt_id_q    <= gnt_id_d;
        end
    end

    // Operand capture needs no reset; contents only matter after a grant.
    always_ff @(posedge clk) begin
        op_a_q <= op_a_d;
        op_b_q <= op_b_d;
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_adder_share_sched.sv
// Bench for adder_share_sched: directed vectors, round-robin, backpressure,
// mid-operation reset and randomized ops against a plain-arithmetic model.
module tb_adder_share_sched;

    localparam int NREQ   = 4;
    localparam int NBYTES = 2;
    localparam int W      = 16;
    localparam int IDW    = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [W:0]        rsp_sum;
    logic              busy;

    logic [W-1:0] opa [NREQ];
    logic [W-1:0] opb [NREQ];

    assign req_a = {opa[3], opa[2], opa[1], opa[0]};
    assign req_b = {opb[3], opb[2], opb[1], opb[0]};

    adder_share_sched #(.NREQ(NREQ), .NBYTES(NBYTES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int errs   = 0;
    int checks = 0;
    int ptr    = 0;

    typedef struct {
        int         id;
        logic [15:0] a;
        logic [15:0] b;
        logic [16:0] sum;
    } vec_t;

    vec_t tv [4];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, want);
        end
    endtask

    function automatic int pick(input logic [3:0] m, input int p);
        for (int j = 0; j < NREQ; j++) begin
            if (m[(p + j) % NREQ]) return (p + j) % NREQ;
        end
        return -1;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        tick;
        tick;
        rst_n = 1'b1;
        ptr   = 0;
        #1;
    endtask

    // One complete transaction; returns the observed id and sum.
    task automatic run_op(input logic [3:0] mask, input int stall,
                          output logic [1:0] got_id, output logic [16:0] got_sum);
        int          g;
        int          n;
        logic [16:0] want;
        logic [1:0]  hid;
        logic [16:0] hsum;
        g = pick(mask, ptr);
        req_valid = mask;
        rsp_ready = 1'b0;
        #1;
        chk("grant", 32'(req_ready), 32'(1) << g);
        want = {1'b0, opa[g]} + {1'b0, opb[g]};
        tick;
        ptr = (g + 1) % NREQ;
        req_valid = '0;
        opa[g] = 16'($urandom);
        opb[g] = 16'($urandom);
        chk("busy in add", 32'(busy), 32'(1));
        n = 0;
        while (!rsp_valid && n < 10) begin
            tick;
            n++;
        end
        chk("latency", 32'(n), 32'(NBYTES));
        hid  = rsp_id;
        hsum = rsp_sum;
        for (int s = 0; s < stall; s++) begin
            req_valid = 4'hF;
            #1;
            chk("stall ready", 32'(req_ready), 32'(0));
            chk("stall valid", 32'(rsp_valid), 32'(1));
            chk("stall id", 32'(rsp_id), 32'(hid));
            chk("stall sum", 32'(rsp_sum), 32'(hsum));
            tick;
        end
        req_valid = '0;
        chk("rsp valid", 32'(rsp_valid), 32'(1));
        chk("rsp id", 32'(rsp_id), 32'(g));
        chk("rsp sum", 32'(rsp_sum), 32'(want));
        got_id  = rsp_id;
        got_sum = rsp_sum;
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
        chk("valid drop", 32'(rsp_valid), 32'(0));
        chk("idle busy", 32'(busy), 32'(0));
        chk("sum held", 32'(rsp_sum), 32'(want));
    endtask

    initial begin
        logic [1:0]  gid;
        logic [16:0] gsum;
        int          gi;
        int          exp_g;
        int          last_c;
        int          ngr;
        int          nrs;
        int          rids [$];

        for (int i = 0; i < NREQ; i++) begin
            opa[i] = '0;
            opb[i] = '0;
        end
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        #2;
        chk("reset valid", 32'(rsp_valid), 32'(0));
        chk("reset busy", 32'(busy), 32'(0));
        chk("reset id", 32'(rsp_id), 32'(0));
        chk("reset sum", 32'(rsp_sum), 32'(0));
        do_reset;
        chk("idle ready", 32'(req_ready), 32'(0));

        tv[0] = '{2, 16'h1234, 16'h0FCD, 17'h02201};
        tv[1] = '{1, 16'h00FF, 16'h0001, 17'h00100};
        tv[2] = '{3, 16'hFFFF, 16'hFFFF, 17'h1FFFE};
        tv[3] = '{0, 16'hFFFF, 16'h0001, 17'h10000};
        for (int i = 0; i < 4; i++) begin
            opa[tv[i].id] = tv[i].a;
            opb[tv[i].id] = tv[i].b;
            run_op(4'(1) << tv[i].id, (i == 1) ? 5 : 0, gid, gsum);
            chk("vec id", 32'(gid), 32'(tv[i].id));
            chk("vec sum", 32'(gsum), 32'(tv[i].sum));
        end

        // rr_ptr at 3 with requesters 1 and 3 pending.
        do_reset;
        opa[2] = 16'h0001;
        opb[2] = 16'h0002;
        run_op(4'b0100, 0, gid, gsum);
        opa[1] = 16'h1111;
        opb[1] = 16'h2222;
        opa[3] = 16'h3333;
        opb[3] = 16'h4444;
        run_op(4'b1010, 0, gid, gsum);
        chk("rr3 first", 32'(gid), 32'(3));
        chk("rr3 sum", 32'(gsum), 32'h07777);
        run_op(4'b1010, 0, gid, gsum);
        chk("rr3 second", 32'(gid), 32'(1));
        chk("rr3 sum2", 32'(gsum), 32'h03333);

        // All requesters held valid with rsp_ready high.
        do_reset;
        for (int i = 0; i < NREQ; i++) begin
            opa[i] = 16'(i * 16'h1111);
            opb[i] = 16'h0101;
        end
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        ngr    = 0;
        nrs    = 0;
        last_c = 0;
        for (int c = 0; c < 40 && ngr < 5; c++) begin
            #1;
            if (rsp_valid) begin
                rids.push_back(int'(rsp_id));
                chk("rr sum", 32'(rsp_sum),
                    32'({1'b0, opa[rsp_id]} + {1'b0, opb[rsp_id]}));
            end
            if (req_ready != 0) begin
                gi = -1;
                for (int i = 0; i < NREQ; i++) if (req_ready[i]) gi = i;
                exp_g = pick(4'hF, ptr);
                chk("rr order", 32'(gi), 32'(exp_g));
                if (ngr > 0) chk("rr spacing", 32'(c - last_c), 32'(NBYTES + 2));
                ptr    = (exp_g + 1) % NREQ;
                last_c = c;
                ngr++;
            end
            tick;
        end
        chk("rr grants", 32'(ngr), 32'(5));
        req_valid = '0;
        for (int i = 0; i < 4; i++) begin
            if (i < rids.size()) chk("rr rsp id", 32'(rids[i]), 32'(i));
            else chk("rr rsp missing", 32'(0), 32'(1));
        end
        for (int c = 0; c < 6; c++) tick;
        rsp_ready = 1'b0;

        // Reset pulse during ADD aborts the operation.
        do_reset;
        opa[2] = 16'hAAAA;
        opb[2] = 16'h5555;
        req_valid = 4'b0100;
        #1;
        chk("abort grant", 32'(req_ready), 32'b0100);
        tick;
        req_valid = '0;
        chk("abort busy pre", 32'(busy), 32'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort valid", 32'(rsp_valid), 32'(0));
        chk("abort busy", 32'(busy), 32'(0));
        tick;
        rst_n = 1'b1;
        ptr   = 0;
        nrs   = 0;
        for (int c = 0; c < 5; c++) begin
            if (rsp_valid) nrs++;
            tick;
        end
        chk("abort no rsp", 32'(nrs), 32'(0));
        req_valid = 4'hF;
        #1;
        chk("post reset grant", 32'(req_ready), 32'b0001);
        opa[0] = 16'h8000;
        opb[0] = 16'h8000;
        run_op(4'hF, 1, gid, gsum);
        chk("post reset id", 32'(gid), 32'(0));

        // Randomized ops.
        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < NREQ; i++) begin
                opa[i] = 16'($urandom);
                opb[i] = 16'($urandom);
            end
            run_op(4'($urandom_range(1, 15)), $urandom_range(0, 3), gid, gsum);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
